// File: rtl/laser_host_if.sv
`default_nettype none
// ============================================================================
// Module   : laser_host_if
// Function : host-control and engine-facing signal bundle for laser_host
// Revision : 1.0
// ============================================================================
interface laser_host_if;
    logic       LD_EN;
    logic [5:0] LD_ADDR;
    logic [3:0] LD_X;
    logic [3:0] LD_Y;
    logic       START;
    logic [3:0] X;
    logic [3:0] Y;
    logic       DUT_RST;
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;
    logic       DONE;
    logic       BUSY;
    logic [5:0] SCORE;
    logic       RESULT_VALID;
    logic       TIMEOUT_ERR;

    modport master (
        output LD_EN, LD_ADDR, LD_X, LD_Y, START,
        output C1X, C1Y, C2X, C2Y, DONE,
        input  X, Y, DUT_RST, BUSY, SCORE, RESULT_VALID, TIMEOUT_ERR
    );

    modport slave (
        input  LD_EN, LD_ADDR, LD_X, LD_Y, START,
        input  C1X, C1Y, C2X, C2Y, DONE,
        output X, Y, DUT_RST, BUSY, SCORE, RESULT_VALID, TIMEOUT_ERR
    );
endinterface
`default_nettype wire

// File: rtl/laser_host.sv
`default_nettype none
// ============================================================================
// Module   : laser_host
// Function : streams a 40-point target set to the placement engine and
//            scores the two returned circle centres in-system
// Revision : 1.0
// ============================================================================
module laser_host #(
    parameter int TIMEOUT = 50000
) (
    input  logic        CLK,
    input  logic        RST,
    laser_host_if.slave bus
);

    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_RSTD   = 3'd1;
    localparam logic [2:0]  c_ST_STREAM = 3'd2;
    localparam logic [2:0]  c_ST_WAIT   = 3'd3;
    localparam logic [2:0]  c_ST_SCORE  = 3'd4;
    localparam logic [2:0]  c_ST_REPORT = 3'd5;
    localparam int          c_NPTS      = 40;
    localparam logic [5:0]  c_LAST_PT   = 6'd39;
    localparam logic [15:0] c_WAIT_LAST = 16'(TIMEOUT - 1);

    logic [7:0]  r_mem [0:c_NPTS-1];
    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [5:0]  r_idx;
    logic [15:0] r_wcnt;
    logic [3:0]  r_c1x, r_c1y, r_c2x, r_c2y;
    logic [5:0]  r_acc;
    logic [3:0]  r_x, r_y;
    logic [5:0]  r_score;
    logic        r_terr;
    logic        w_busy, w_dut_rst, w_result_valid;
    logic        w_last_pt;
    logic [5:0]  w_fetch_idx;
    logic [7:0]  w_fetch_pt;
    logic [7:0]  w_score_pt;
    logic        w_covered;

    // Squared Euclidean distance kept at full 9-bit precision, radius^2 = 16.
    function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [8:0] d2;
        dx = (px >= cx) ? (px - cx) : (cx - px);
        dy = (py >= cy) ? (py - cy) : (cy - py);
        d2 = ({5'd0, dx} * {5'd0, dx}) + ({5'd0, dy} * {5'd0, dy});
        return (d2 <= 9'd16);
    endfunction

    // Point memory deliberately survives reset so a frame can be rerun.
    always_ff @(posedge CLK) begin
        if ((r_state == c_ST_IDLE) && bus.LD_EN && (bus.LD_ADDR < 6'(c_NPTS)))
            r_mem[bus.LD_ADDR] <= {bus.LD_X, bus.LD_Y};
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= c_ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (bus.START) w_next_state = c_ST_RSTD;
            c_ST_RSTD:   w_next_state = c_ST_STREAM;
            c_ST_STREAM: if (w_last_pt) w_next_state = c_ST_WAIT;
            c_ST_WAIT: begin
                if (bus.DONE)                    w_next_state = c_ST_SCORE;
                else if (r_wcnt == c_WAIT_LAST)  w_next_state = c_ST_REPORT;
            end
            c_ST_SCORE:  if (w_last_pt) w_next_state = c_ST_REPORT;
            c_ST_REPORT: w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy         = (r_state != c_ST_IDLE);
        w_dut_rst      = (r_state == c_ST_RSTD);
        w_result_valid = (r_state == c_ST_REPORT);
    end

    assign w_last_pt   = (r_idx == c_LAST_PT);
    // Look one point ahead so X/Y are registered in the cycle they are needed.
    assign w_fetch_idx = ((r_state == c_ST_STREAM) && !w_last_pt) ? (r_idx + 6'd1) : 6'd0;
    assign w_fetch_pt  = r_mem[w_fetch_idx];
    assign w_score_pt  = r_mem[r_idx];
    assign w_covered   = in_circle(w_score_pt[7:4], w_score_pt[3:0], r_c1x, r_c1y)
                       | in_circle(w_score_pt[7:4], w_score_pt[3:0], r_c2x, r_c2y);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idx   <= 6'd0;
            r_wcnt  <= 16'd0;
            r_c1x   <= 4'd0;
            r_c1y   <= 4'd0;
            r_c2x   <= 4'd0;
            r_c2y   <= 4'd0;
            r_acc   <= 6'd0;
            r_x     <= 4'd0;
            r_y     <= 4'd0;
            r_score <= 6'd0;
            r_terr  <= 1'b0;
        end else begin
            r_idx  <= ((w_next_state == r_state) &&
                       ((r_state == c_ST_STREAM) || (r_state == c_ST_SCORE))) ? (r_idx + 6'd1) : 6'd0;
            r_wcnt <= ((r_state == c_ST_WAIT) && (w_next_state == c_ST_WAIT)) ? (r_wcnt + 16'd1) : 16'd0;
            if ((r_state == c_ST_WAIT) && bus.DONE) begin
                r_c1x <= bus.C1X;
                r_c1y <= bus.C1Y;
                r_c2x <= bus.C2X;
                r_c2y <= bus.C2Y;
            end
            r_acc <= (r_state == c_ST_SCORE) ? (r_acc + {5'd0, w_covered}) : 6'd0;
            r_x   <= (w_next_state == c_ST_STREAM) ? w_fetch_pt[7:4] : 4'd0;
            r_y   <= (w_next_state == c_ST_STREAM) ? w_fetch_pt[3:0] : 4'd0;
            // Result registers load on REPORT entry so they are valid with the strobe.
            if (w_next_state == c_ST_REPORT) begin
                if (r_state == c_ST_SCORE) begin
                    r_score <= r_acc + {5'd0, w_covered};
                    r_terr  <= 1'b0;
                end else begin
                    r_score <= 6'd0;
                    r_terr  <= 1'b1;
                end
            end
        end
    end

    assign bus.X            = r_x;
    assign bus.Y            = r_y;
    assign bus.DUT_RST      = w_dut_rst;
    assign bus.BUSY         = w_busy;
    assign bus.SCORE        = r_score;
    assign bus.RESULT_VALID = w_result_valid;
    assign bus.TIMEOUT_ERR  = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_laser_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_laser_host
// Function : randomized bench for laser_host against a point-coverage model
// Revision : 1.0
// ============================================================================
module tb_laser_host;
    localparam int TO = 100;

    logic CLK = 1'b0;
    logic RST;
    laser_host_if bus();

    laser_host #(.TIMEOUT(TO)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    int m_x [40];
    int m_y [40];

    logic [3:0] obs_x [40];
    logic [3:0] obs_y [40];
    logic       obs_rst_pre, obs_busy_pre, obs_busy_post, obs_terr;
    logic [3:0] obs_wait_x, obs_wait_y;
    logic [5:0] obs_score, obs_score_hold;
    int         obs_rst_total, obs_rv_t, obs_rv_cnt;

    function automatic int model_score(input int c1x, input int c1y, input int c2x, input int c2y);
        int s;
        int d1;
        int d2;
        s = 0;
        for (int k = 0; k < 40; k++) begin
            d1 = (m_x[k] - c1x) * (m_x[k] - c1x) + (m_y[k] - c1y) * (m_y[k] - c1y);
            d2 = (m_x[k] - c2x) * (m_x[k] - c2x) + (m_y[k] - c2y) * (m_y[k] - c2y);
            if (d1 <= 16 || d2 <= 16) s++;
        end
        return s;
    endfunction

    task automatic load_point(input int a, input int px, input int py);
        @(negedge CLK);
        bus.LD_EN = 1'b1; bus.LD_ADDR = 6'(a); bus.LD_X = 4'(px); bus.LD_Y = 4'(py);
        if (a < 40) begin m_x[a] = px; m_y[a] = py; end
        @(negedge CLK);
        bus.LD_EN = 1'b0;
    endtask

    task automatic load_random;
        for (int k = 0; k < 40; k++) load_point(k, $urandom_range(0, 15), $urandom_range(0, 15));
    endtask

    task automatic run_frame(input int done_at, input int c1x, input int c1y, input int c2x, input int c2y,
                             input bit glitch, input bit poke, input int ld_addr, input int ld_px, input int ld_py);
        @(negedge CLK);
        bus.START = 1'b1;
        if (ld_addr >= 0) begin
            bus.LD_EN = 1'b1; bus.LD_ADDR = 6'(ld_addr); bus.LD_X = 4'(ld_px); bus.LD_Y = 4'(ld_py);
            if (ld_addr < 40) begin m_x[ld_addr] = ld_px; m_y[ld_addr] = ld_py; end
        end
        @(negedge CLK);
        bus.START = 1'b0; bus.LD_EN = 1'b0;
        obs_rst_pre = bus.DUT_RST; obs_busy_pre = bus.BUSY; obs_rst_total = int'(bus.DUT_RST);
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            obs_x[k] = bus.X; obs_y[k] = bus.Y;
            obs_rst_total += int'(bus.DUT_RST);
            bus.START = 1'b0; bus.LD_EN = 1'b0; bus.DONE = 1'b0;
            if (glitch) begin
                bus.DONE = 1'($urandom_range(0, 1));
                bus.C1X = 4'($urandom); bus.C1Y = 4'($urandom); bus.C2X = 4'($urandom); bus.C2Y = 4'($urandom);
            end
            if (poke && k == 10) begin
                bus.START = 1'b1; bus.LD_EN = 1'b1; bus.LD_ADDR = 6'd0;
                bus.LD_X = 4'(15 - m_x[0]); bus.LD_Y = 4'(15 - m_y[0]);
            end
        end
        obs_rv_t = -1; obs_rv_cnt = 0; obs_busy_post = 1'bx;
        obs_score = 'x; obs_terr = 1'bx; obs_score_hold = 'x;
        for (int t = 1; t <= TO + 60; t++) begin
            @(negedge CLK);
            if (t == 1) begin obs_wait_x = bus.X; obs_wait_y = bus.Y; end
            obs_rst_total += int'(bus.DUT_RST);
            if (bus.RESULT_VALID === 1'b1) begin
                obs_rv_cnt++;
                if (obs_rv_t < 0) begin obs_rv_t = t; obs_score = bus.SCORE; obs_terr = bus.TIMEOUT_ERR; end
            end
            if (obs_rv_t > 0 && t == obs_rv_t + 1) obs_busy_post = bus.BUSY;
            if (obs_rv_t > 0 && t == obs_rv_t + 4) begin obs_score_hold = bus.SCORE; break; end
            bus.START = 1'b0; bus.LD_EN = 1'b0; bus.DONE = 1'b0;
            bus.C1X = 4'($urandom); bus.C1Y = 4'($urandom); bus.C2X = 4'($urandom); bus.C2Y = 4'($urandom);
            if (t == done_at + 1) begin
                bus.DONE = 1'b1;
                bus.C1X = 4'(c1x); bus.C1Y = 4'(c1y); bus.C2X = 4'(c2x); bus.C2Y = 4'(c2y);
            end
            if (poke && t == 2) begin
                bus.START = 1'b1; bus.LD_EN = 1'b1; bus.LD_ADDR = 6'd0;
                bus.LD_X = 4'(15 - m_x[0]); bus.LD_Y = 4'(15 - m_y[0]);
            end
        end
        bus.START = 1'b0; bus.LD_EN = 1'b0; bus.DONE = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_vec++; if (bus.X !== 4'd0 || bus.Y !== 4'd0) begin n_err++; $display("FAIL reset_xy: got %0d,%0d want 0,0", bus.X, bus.Y); end
        n_vec++; if (bus.DUT_RST !== 1'b0) begin n_err++; $display("FAIL reset_dut_rst: got %b want 0", bus.DUT_RST); end
        n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        n_vec++; if (bus.SCORE !== 6'd0) begin n_err++; $display("FAIL reset_score: got %0d want 0", bus.SCORE); end
        n_vec++; if (bus.RESULT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.RESULT_VALID); end
        n_vec++; if (bus.TIMEOUT_ERR !== 1'b0) begin n_err++; $display("FAIL reset_terr: got %b want 0", bus.TIMEOUT_ERR); end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", bus.BUSY); end
    endtask

    task automatic test_all_covered;
        int exp;
        for (int k = 0; k < 40; k++) load_point(k, 3, 3);
        exp = model_score(3, 3, 10, 10);
        run_frame(5, 3, 3, 10, 10, 1'b0, 1'b0, -1, 0, 0);
        n_vec++; if (obs_score !== 6'(exp)) begin n_err++; $display("FAIL all_cov_score: got %0d want %0d", obs_score, exp); end
        n_vec++; if (obs_terr !== 1'b0) begin n_err++; $display("FAIL all_cov_terr: got %b want 0", obs_terr); end
        n_vec++; if (obs_rv_t != 5 + 42) begin n_err++; $display("FAIL all_cov_latency: got %0d want %0d", obs_rv_t, 5 + 42); end
        n_vec++; if (obs_rv_cnt != 1) begin n_err++; $display("FAIL all_cov_strobe: got %0d cycles want 1", obs_rv_cnt); end
        n_vec++; if (obs_busy_post !== 1'b0) begin n_err++; $display("FAIL all_cov_idle: busy got %b want 0", obs_busy_post); end
    endtask

    task automatic test_split;
        int cx1 [3] = '{4, 3, 0};
        int cy1 [3] = '{0, 3, 0};
        int cx2 [3] = '{15, 8, 0};
        int cy2 [3] = '{15, 8, 0};
        int exp;
        for (int k = 0; k < 40; k++) load_point(k, (k < 20) ? 0 : 15, (k < 20) ? 0 : 15);
        for (int i = 0; i < 3; i++) begin
            exp = model_score(cx1[i], cy1[i], cx2[i], cy2[i]);
            run_frame($urandom_range(0, 10), cx1[i], cy1[i], cx2[i], cy2[i], 1'b0, 1'b0, -1, 0, 0);
            n_vec++; if (obs_score !== 6'(exp)) begin n_err++; $display("FAIL split_score[%0d]: got %0d want %0d", i, obs_score, exp); end
            n_vec++; if (obs_rv_cnt != 1) begin n_err++; $display("FAIL split_strobe[%0d]: got %0d want 1", i, obs_rv_cnt); end
        end
    endtask

    task automatic test_boundary;
        int exp;
        for (int k = 0; k < 40; k++) load_point(k, 0, 0);
        load_point(0, 12, 15);
        load_point(1, 11, 15);
        load_point(2, 15, 9);
        load_point(3, 11, 13);
        load_point(4, 10, 13);
        exp = model_score(0, 8, 15, 13);
        run_frame(1, 0, 8, 15, 13, 1'b0, 1'b0, -1, 0, 0);
        n_vec++; if (obs_score !== 6'(exp)) begin n_err++; $display("FAIL boundary_c2: got %0d want %0d", obs_score, exp); end
        exp = model_score(15, 13, 0, 8);
        run_frame(0, 15, 13, 0, 8, 1'b0, 1'b0, -1, 0, 0);
        n_vec++; if (obs_score !== 6'(exp)) begin n_err++; $display("FAIL boundary_c1: got %0d want %0d", obs_score, exp); end
    endtask

    task automatic test_stream;
        int exp;
        for (int k = 0; k < 40; k++) load_point(k, k % 16, (k * 7) % 16);
        for (int a = 40; a < 64; a++) load_point(a, $urandom_range(0, 15), $urandom_range(0, 15));
        exp = model_score(5, 5, 12, 3);
        run_frame(2, 5, 5, 12, 3, 1'b1, 1'b0, -1, 0, 0);
        for (int k = 0; k < 40; k++) begin
            n_vec++;
            if (obs_x[k] !== 4'(m_x[k]) || obs_y[k] !== 4'(m_y[k])) begin
                n_err++; $display("FAIL stream[%0d]: got %0d,%0d want %0d,%0d", k, obs_x[k], obs_y[k], m_x[k], m_y[k]);
            end
        end
        n_vec++; if (obs_rst_pre !== 1'b1) begin n_err++; $display("FAIL dut_rst_pos: got %b want 1", obs_rst_pre); end
        n_vec++; if (obs_rst_total != 1) begin n_err++; $display("FAIL dut_rst_width: got %0d want 1", obs_rst_total); end
        n_vec++; if (obs_busy_pre !== 1'b1) begin n_err++; $display("FAIL busy_rstd: got %b want 1", obs_busy_pre); end
        n_vec++; if (obs_wait_x !== 4'd0 || obs_wait_y !== 4'd0) begin n_err++; $display("FAIL wait_xy: got %0d,%0d want 0,0", obs_wait_x, obs_wait_y); end
        n_vec++; if (obs_score !== 6'(exp)) begin n_err++; $display("FAIL stream_score: got %0d want %0d", obs_score, exp); end
    endtask

    task automatic test_timeout;
        load_random();
        run_frame(-1, 0, 0, 0, 0, 1'b0, 1'b0, -1, 0, 0);
        n_vec++; if (obs_rv_t != TO + 1) begin n_err++; $display("FAIL timeout_latency: got %0d want %0d", obs_rv_t, TO + 1); end
        n_vec++; if (obs_terr !== 1'b1) begin n_err++; $display("FAIL timeout_terr: got %b want 1", obs_terr); end
        n_vec++; if (obs_score !== 6'd0) begin n_err++; $display("FAIL timeout_score: got %0d want 0", obs_score); end
        n_vec++; if (obs_rv_cnt != 1) begin n_err++; $display("FAIL timeout_strobe: got %0d want 1", obs_rv_cnt); end
        n_vec++; if (obs_busy_post !== 1'b0) begin n_err++; $display("FAIL timeout_idle: busy got %b want 0", obs_busy_post); end
        n_vec++; if (obs_score_hold !== 6'd0) begin n_err++; $display("FAIL timeout_hold: got %0d want 0", obs_score_hold); end
    endtask

    task automatic test_done_at_timeout;
        int exp;
        exp = model_score(m_x[7], m_y[7], m_x[30], m_y[30]);
        run_frame(TO - 1, m_x[7], m_y[7], m_x[30], m_y[30], 1'b0, 1'b0, -1, 0, 0);
        n_vec++; if (obs_terr !== 1'b0) begin n_err++; $display("FAIL done_wins_terr: got %b want 0", obs_terr); end
        n_vec++; if (obs_rv_t != TO - 1 + 42) begin n_err++; $display("FAIL done_wins_latency: got %0d want %0d", obs_rv_t, TO + 41); end
        n_vec++; if (obs_score !== 6'(exp)) begin n_err++; $display("FAIL done_wins_score: got %0d want %0d", obs_score, exp); end
    endtask

    task automatic test_rst_midframe;
        int exp;
        int rv_seen;
        int busy_seen;
        int bad;
        load_random();
        run_frame(3, m_x[0], m_y[0], m_x[1], m_y[1], 1'b0, 1'b0, -1, 0, 0);
        @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (21) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_vec++; if (bus.BUSY !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.BUSY); end
        n_vec++; if (bus.X !== 4'd0 || bus.Y !== 4'd0) begin n_err++; $display("FAIL midrst_xy: got %0d,%0d want 0,0", bus.X, bus.Y); end
        n_vec++; if (bus.SCORE !== 6'd0 || bus.TIMEOUT_ERR !== 1'b0) begin n_err++; $display("FAIL midrst_result: got %0d/%b want 0/0", bus.SCORE, bus.TIMEOUT_ERR); end
        rv_seen = 0; busy_seen = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge CLK);
            rv_seen += int'(bus.RESULT_VALID);
            busy_seen += int'(bus.BUSY);
        end
        n_vec++; if (rv_seen != 0 || busy_seen != 0) begin n_err++; $display("FAIL midrst_quiet: valid %0d busy %0d want 0 0", rv_seen, busy_seen); end
        exp = model_score(m_x[5], m_y[5], 7, 7);
        run_frame(4, m_x[5], m_y[5], 7, 7, 1'b0, 1'b0, -1, 0, 0);
        bad = 0;
        for (int k = 0; k < 40; k++) if (obs_x[k] !== 4'(m_x[k]) || obs_y[k] !== 4'(m_y[k])) bad++;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL midrst_restream: got %0d bad points want 0", bad); end
        n_vec++; if (obs_score !== 6'(exp)) begin n_err++; $display("FAIL midrst_score: got %0d want %0d", obs_score, exp); end
    endtask

    task automatic test_busy_ignore;
        int exp;
        exp = model_score(m_x[0], m_y[0], m_x[39], m_y[39]);
        run_frame(6, m_x[0], m_y[0], m_x[39], m_y[39], 1'b0, 1'b1, -1, 0, 0);
        n_vec++; if (obs_score !== 6'(exp)) begin n_err++; $display("FAIL poke_score: got %0d want %0d", obs_score, exp); end
        n_vec++; if (obs_rv_t != 6 + 42 || obs_rv_cnt != 1) begin n_err++; $display("FAIL poke_timing: rv at %0d x%0d want %0d x1", obs_rv_t, obs_rv_cnt, 48); end
        n_vec++; if (obs_busy_post !== 1'b0) begin n_err++; $display("FAIL poke_restart: busy got %b want 0", obs_busy_post); end
        run_frame(2, 8, 8, 8, 8, 1'b0, 1'b0, -1, 0, 0);
        n_vec++; if (obs_x[0] !== 4'(m_x[0]) || obs_y[0] !== 4'(m_y[0])) begin n_err++; $display("FAIL poke_mem: got %0d,%0d want %0d,%0d", obs_x[0], obs_y[0], m_x[0], m_y[0]); end
    endtask

    task automatic test_random;
        int exp, d, c1x, c1y, c2x, c2y, la;
        for (int f = 0; f < 5; f++) begin
            load_random();
            c1x = $urandom_range(0, 15); c1y = $urandom_range(0, 15);
            c2x = $urandom_range(0, 15); c2y = $urandom_range(0, 15);
            d = $urandom_range(0, 30);
            la = (f == 0) ? int'($urandom_range(0, 39)) : -1;
            if (la >= 0) begin m_x[la] = c1x; m_y[la] = c1y; end
            exp = model_score(c1x, c1y, c2x, c2y);
            run_frame(d, c1x, c1y, c2x, c2y, 1'b1, 1'b0, la, c1x, c1y);
            n_vec++; if (obs_score !== 6'(exp)) begin n_err++; $display("FAIL rand_score[%0d]: got %0d want %0d", f, obs_score, exp); end
            n_vec++; if (obs_terr !== 1'b0) begin n_err++; $display("FAIL rand_terr[%0d]: got %b want 0", f, obs_terr); end
            n_vec++; if (obs_rv_t != d + 42 || obs_rv_cnt != 1) begin n_err++; $display("FAIL rand_timing[%0d]: rv at %0d x%0d want %0d x1", f, obs_rv_t, obs_rv_cnt, d + 42); end
            n_vec++; if (obs_score_hold !== 6'(exp)) begin n_err++; $display("FAIL rand_hold[%0d]: got %0d want %0d", f, obs_score_hold, exp); end
            if (la >= 0) begin
                n_vec++; if (obs_x[la] !== 4'(c1x) || obs_y[la] !== 4'(c1y)) begin n_err++; $display("FAIL start_with_load: got %0d,%0d want %0d,%0d", obs_x[la], obs_y[la], c1x, c1y); end
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.LD_EN = 1'b0; bus.LD_ADDR = 6'd0; bus.LD_X = 4'd0; bus.LD_Y = 4'd0;
        bus.START = 1'b0; bus.DONE = 1'b0;
        bus.C1X = 4'd0; bus.C1Y = 4'd0; bus.C2X = 4'd0; bus.C2Y = 4'd0;
        for (int k = 0; k < 40; k++) begin m_x[k] = 0; m_y[k] = 0; end
        test_reset();
        test_all_covered();
        test_split();
        test_boundary();
        test_stream();
        test_timeout();
        test_done_at_timeout();
        test_rst_midframe();
        test_busy_ignore();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
